// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder: 4x4 matrix keypad scanner with debounce, one-cycle keystrobe and registered keycode
module keypad_scan_encoder #(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic       keystrobe,
  output logic [3:0] keycode
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  // nibble {row,col} holds the keycode for that key, row 0 col 0 in the low nibble
  localparam logic [63:0] KMAP = 64'hDF0E_C987_B654_A321;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;
  state_t        state, state_nx;
  logic [3:0]    sync1, cols_s, rows_nx, keycode_nx;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    col_idx, row_idx, cand_col, cand_nx;
  logic          tick, valid, match, done, rel_done, rotate, strobe_nx;
  assign tick     = div == DW'(SCAN_DIV - 1);
  assign valid    = cols_s != 4'd0 && (cols_s & (cols_s - 4'd1)) == 4'd0;
  assign col_idx  = cols_s[3] ? 2'd3 : cols_s[2] ? 2'd2 : cols_s[1] ? 2'd1 : 2'd0;
  assign row_idx  = rows[3] ? 2'd3 : rows[2] ? 2'd2 : rows[1] ? 2'd1 : 2'd0;
  assign match    = valid && col_idx == cand_col;
  assign done     = state == DEBOUNCE && cnt == CW'(DEBOUNCE_CNT);
  assign rel_done = state == HELD && tick && cols_s == 4'd0 && cnt == CW'(DEBOUNCE_CNT - 1);
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync1     <= 4'd0;
      cols_s    <= 4'd0;
      state     <= SCAN;
      div       <= '0;
      cnt       <= '0;
      cand_col  <= 2'd0;
      rows      <= 4'b0001;
      keystrobe <= 1'b0;
      keycode   <= 4'h0;
    end else begin
      sync1     <= cols;
      cols_s    <= sync1;
      state     <= state_nx;
      div       <= tick ? '0 : div + DW'(1);
      cnt       <= cnt_nx;
      cand_col  <= cand_nx;
      rows      <= rows_nx;
      keystrobe <= strobe_nx;
      keycode   <= keycode_nx;
    end
  end
  always_comb begin
    state_nx = state == SCAN     ? (tick && valid ? DEBOUNCE : SCAN)
             : state == DEBOUNCE ? (done ? HELD : tick && !match ? SCAN : DEBOUNCE)
             : state == HELD     ? (rel_done ? SCAN : HELD)
             : SCAN;
  end
  // rotation only happens on a tick, so the divider wrap doubles as its restart
  always_comb begin
    rotate     = state_nx == SCAN && (state != SCAN || tick);
    rows_nx    = rotate ? {rows[2:0], rows[3]} : rows;
    cand_nx    = state == SCAN && tick && valid ? col_idx : cand_col;
    strobe_nx  = done;
    keycode_nx = done ? KMAP[{row_idx, cand_col, 2'b00} +: 4] : keycode;
    cnt_nx     = state == SCAN     ? (tick && valid ? CW'(1) : CW'(0))
               : state == DEBOUNCE ? (done ? CW'(0) : tick && match ? cnt + CW'(1) : cnt)
               : state == HELD     ? (rel_done ? CW'(0) : !tick ? cnt : cols_s == 4'd0 ? cnt + CW'(1) : CW'(0))
               : CW'(0);
  end
endmodule

// File: tb/tb_keypad_scan_encoder.sv
// tb_keypad_scan_encoder: keypad model plus spec-level expectations (key map, one strobe per press, latency, rotation)
module tb_keypad_scan_encoder;
  localparam int SD = 4;
  localparam int DB = 3;
  localparam int LAT = SD * DB + 1;
  logic tb_clk = 1'b0;
  logic nrst = 1'b0;
  logic [3:0] cols, rows, keycode, ovr = 4'd0;
  logic keystrobe, ovr_en = 1'b0;
  logic [15:0] pressed = 16'd0;
  int n_cmp = 0, n_bad = 0, strobe_cnt = 0, n_rot = 0, since = 0;
  logic prev_strobe = 1'b0;
  logic [3:0] prev_kc = 4'd0, prev_rows = 4'd0;
  int kmap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  keypad_scan_encoder #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk(tb_clk), .nrst(nrst), .cols(cols), .rows(rows), .keystrobe(keystrobe), .keycode(keycode)
  );
  always #5 tb_clk = ~tb_clk;
  // physical keypad: a pressed key shorts its column to the driven row
  always_comb begin
    logic [3:0] cm;
    cm = 4'd0;
    for (int r = 0; r < 4; r++) if (rows[r]) cm |= pressed[4*r +: 4];
    cols = ovr_en ? ovr : cm;
  end
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  always @(posedge tb_clk) begin
    #1;
    if (rows != prev_rows) begin
      since = 0;
      n_rot++;
    end else since++;
    if (keystrobe) begin
      strobe_cnt++;
      check("no_double_strobe", prev_strobe, 0);
      check("latency", since, LAT);
    end
    if (nrst && keycode != prev_kc) check("keycode_only_on_strobe", keystrobe, 1);
    prev_strobe = keystrobe;
    prev_kc = keycode;
    prev_rows = rows;
  end
  task automatic press(input int k);
    int t;
    for (t = 0; t < 100 && rows[k/4]; t++) @(negedge tb_clk);
    if (t == 100) check("press_wait_timeout", 0, 1);
    pressed[k] = 1'b1;
  endtask
  task automatic expect_strobe(input int k);
    int s0, t;
    s0 = strobe_cnt;
    for (t = 0; t < 200 && strobe_cnt == s0; t++) @(negedge tb_clk);
    check("strobe_seen", strobe_cnt - s0, 1);
    check("keycode", keycode, kmap[k]);
  endtask
  task automatic hold(input int k, input int n);
    int s0;
    s0 = strobe_cnt;
    repeat (n) @(negedge tb_clk);
    check("no_repeat", strobe_cnt - s0, 0);
    check("rows_held", rows, 1 << (k / 4));
  endtask
  task automatic release_key(input int k);
    int t;
    logic [3:0] r0;
    pressed = 16'd0;
    r0 = rows;
    for (t = 0; t < 100 && rows == r0; t++) @(negedge tb_clk);
    check("release_rotate", rows, 1 << ((k / 4 + 1) % 4));
  endtask
  task automatic press_cycle(input int k, input int n);
    press(k);
    expect_strobe(k);
    hold(k, n);
    release_key(k);
  endtask
  initial begin
    int s0, r0, t;
    ovr_en = 1'b1;
    ovr = 4'b1111;
    repeat (2) begin
      @(posedge tb_clk);
      #1;
      check("rst_rows", rows, 1);
      check("rst_strobe", keystrobe, 0);
      check("rst_keycode", keycode, 0);
    end
    @(negedge tb_clk);
    ovr = 4'd0;
    nrst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      repeat (i == 0 ? 1 : SD) @(posedge tb_clk);
      #1;
      check("rotate_seq", rows, 1 << (i % 4));
    end
    @(negedge tb_clk);
    ovr_en = 1'b0;
    press_cycle(5, 100);
    press_cycle(14, 30);
    check("keycode_holds", keycode, 15);
    press_cycle(0, 30);
    press(10);
    for (t = 0; t < 100 && rows != 4'b0100; t++) @(negedge tb_clk);
    s0 = strobe_cnt;
    repeat (5) @(negedge tb_clk);
    pressed = 16'd0;
    repeat (40) @(negedge tb_clk);
    check("bounce_no_strobe", strobe_cnt - s0, 0);
    press_cycle(10, 20);
    for (t = 0; t < 100 && rows == 4'b0001; t++) @(negedge tb_clk);
    pressed = 16'h0003;
    s0 = strobe_cnt;
    r0 = n_rot;
    repeat (48) @(negedge tb_clk);
    check("multi_no_strobe", strobe_cnt - s0, 0);
    check("multi_rotating", (n_rot - r0) >= 11, 1);
    for (t = 0; t < 100 && rows == 4'b0001; t++) @(negedge tb_clk);
    pressed = 16'h0001;
    expect_strobe(0);
    hold(0, 20);
    release_key(0);
    press(8);
    expect_strobe(8);
    repeat (10) @(negedge tb_clk);
    nrst = 1'b0;
    @(posedge tb_clk);
    #1;
    check("midheld_rst_rows", rows, 1);
    check("midheld_rst_strobe", keystrobe, 0);
    check("midheld_rst_keycode", keycode, 0);
    @(negedge tb_clk);
    nrst = 1'b1;
    expect_strobe(8);
    hold(8, 20);
    release_key(8);
    for (int i = 0; i < 20; i++) press_cycle(int'($urandom_range(0, 15)), int'($urandom_range(10, 60)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
